// File: rtl/io_uart_bridge.sv
// Serial (8N1) bridge for the core's word-wide IN/OUT interface:
// OUT words leave as 4 bytes MSB-first, 4 received bytes form one IN word.
module io_uart_bridge #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        out_req,
    input  logic [31:0] out_data,
    output logic        out_ack,
    input  logic        in_req,
    output logic [31:0] in_data,
    output logic        in_valid,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        busy,
    output logic        rx_frame_err,
    output logic        rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t     r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [1:0]    r_tx_byte;
    logic [31:0]   r_tx_word;
    logic          r_armed;
    logic          r_out_ack;
    logic          w_tx_accept;
    logic          w_tx_tick;
    logic          w_tx_line;
    logic [7:0]    w_tx_cur;

    assign w_tx_tick = (r_tx_cnt == LAST);
    assign w_tx_cur  = r_tx_word[31:24];

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_accept = 1'b0;
        w_tx_line   = 1'b1;
        case (r_tx_state)
            T_IDLE: begin
                if (out_req && r_armed) begin
                    w_tx_accept = 1'b1;
                    w_tx_next   = T_START;
                end
            end
            T_START: begin
                w_tx_line = 1'b0;
                if (w_tx_tick) w_tx_next = T_DATA;
            end
            T_DATA: begin
                w_tx_line = w_tx_cur[r_tx_bit];
                if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = T_STOP;
            end
            T_STOP: begin
                if (w_tx_tick) w_tx_next = (r_tx_byte == 2'd3) ? T_IDLE : T_START;
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_word  <= '0;
            r_armed    <= 1'b0;
            r_out_ack  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_out_ack  <= w_tx_accept;
            // A held request sends once; it must drop before the next word.
            if (!out_req)         r_armed <= 1'b1;
            else if (w_tx_accept) r_armed <= 1'b0;
            if (r_tx_state == T_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                    r_tx_cnt <= r_tx_cnt + CW'(1);
            if (w_tx_accept) r_tx_word <= out_data;
            if (r_tx_state == T_DATA && w_tx_tick) r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_state == T_STOP && w_tx_tick) begin
                r_tx_byte <= r_tx_byte + 2'd1;
                r_tx_word <= {r_tx_word[23:0], 8'h00};
            end
        end
    end

    assign uart_tx = w_tx_line;
    assign busy    = (r_tx_state != T_IDLE);
    assign out_ack = r_out_ack;

    // ---------------- receiver ----------------
    rx_state_t     r_rx_state, w_rx_next;
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [23:0]   r_rx_asm;
    logic [1:0]    r_rx_nbyte;
    logic          r_pend;
    logic [31:0]   r_pend_word;
    logic [31:0]   r_in_data;
    logic          r_in_valid;
    logic          r_frame_err;
    logic          r_overrun;
    logic          w_rx_tick, w_rx_half;
    logic          w_byte_done, w_frame_bad, w_word_done, w_deliver;

    assign w_rx_tick = (r_rx_cnt == LAST);
    assign w_rx_half = (r_rx_cnt == HALF);

    always_comb begin
        w_rx_next   = r_rx_state;
        w_byte_done = 1'b0;
        w_frame_bad = 1'b0;
        case (r_rx_state)
            R_IDLE:  if (r_rx_d && !r_rx_s2) w_rx_next = R_START;
            R_START: if (w_rx_half) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = R_STOP;
            R_STOP: begin
                if (w_rx_tick) begin
                    w_rx_next   = R_IDLE;
                    w_byte_done = r_rx_s2;
                    w_frame_bad = !r_rx_s2;
                end
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    assign w_word_done = w_byte_done && (r_rx_nbyte == 2'd3);
    assign w_deliver   = r_pend && in_req;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_d      <= 1'b1;
            r_rx_state  <= R_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_asm    <= '0;
            r_rx_nbyte  <= '0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
            r_in_data   <= '0;
            r_in_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_next;
            if (r_rx_state == R_IDLE || (r_rx_state == R_START && w_rx_half) || w_rx_tick)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + CW'(1);
            if (r_rx_state == R_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (w_byte_done) begin
                r_rx_asm   <= {r_rx_asm[15:0], r_rx_shift};
                r_rx_nbyte <= r_rx_nbyte + 2'd1;
            end
            if (w_frame_bad) begin
                r_rx_asm    <= '0;
                r_rx_nbyte  <= '0;
                r_frame_err <= 1'b1;
            end
            r_in_valid <= w_deliver;
            if (w_deliver) r_in_data <= r_pend_word;
            // Completion wins over delivery: the old word goes out, the new one waits.
            if (w_word_done) begin
                r_pend      <= 1'b1;
                r_pend_word <= {r_rx_asm, r_rx_shift};
                if (r_pend && !w_deliver) r_overrun <= 1'b1;
            end else if (w_deliver) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign in_data      = r_in_data;
    assign in_valid     = r_in_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_io_uart_bridge.sv
// Directed self-checking bench for io_uart_bridge at CLKS_PER_BIT=4.
module tb_io_uart_bridge;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        reset, out_req, in_req, uart_rx;
    logic [31:0] out_data;
    logic        out_ack, in_valid, uart_tx, busy, rx_frame_err, rx_overrun;
    logic [31:0] in_data;

    io_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .reset(reset),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .in_req(in_req), .in_data(in_data), .in_valid(in_valid),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .busy(busy),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int iv_count = 0, iv_last_cyc = 0, ack_count = 0;
    int n_checks = 0, n_pass = 0;
    int last_start, n0, a0, bcnt, x;
    logic [39:0] txbits;
    logic [31:0] exp_word;
    logic [7:0]  part;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (in_valid) begin
            iv_count++;
            iv_last_cyc = cyc;
        end
        if (out_ack) ack_count++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_iv(input int base);
        for (int i = 0; i < 20; i++) begin
            if (iv_count != base) break;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; out_req = 1'b0; in_req = 1'b0; uart_rx = 1'b1; out_data = '0;
        repeat (3) tick();
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", out_ack, 0);
        check("rst_in_data", in_data, 0);
        check("rst_in_valid", in_valid, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: one word out
        exp_word = 32'h12345678;
        out_data = exp_word;
        check("ack_before", out_ack, 0);
        out_req = 1'b1;
        a0 = ack_count;
        tick();
        out_req = 1'b0;
        check("ack_pulse", out_ack, 1);
        check("busy_rise", busy, 1);
        bcnt = 0;
        for (int i = 0; i < 160; i++) begin
            if (busy) bcnt++;
            if (i % 4 == 2) txbits[i/4] = uart_tx;
            tick();
        end
        for (int b = 0; b < 4; b++)
            check($sformatf("tx_frame%0d", b), {22'd0, txbits[10*b +: 10]},
                  {22'd0, 1'b1, exp_word[31-8*b -: 8], 1'b0});
        check("busy_len", bcnt, 160);
        check("busy_fall", busy, 0);
        check("tx_idle", uart_tx, 1);
        check("ack_count1", ack_count - a0, 1);
        repeat (8) tick();
        check("tx_stays_idle", uart_tx, 1);

        // 2: word in with in_req high
        in_req = 1'b1;
        n0 = iv_count;
        send_word(32'hDEADBEEF);
        wait_iv(n0);
        repeat (4) tick();
        check("rx2_pulses", iv_count - n0, 1);
        check("rx2_latency", iv_last_cyc, last_start + 42);
        check("rx2_data", in_data, 32'hDEADBEEF);
        check("rx2_ferr", rx_frame_err, 0);
        check("rx2_ovr", rx_overrun, 0);

        // 5a: one-cycle glitch then a clean word
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        n0 = iv_count;
        repeat (20) tick();
        check("glitch_noword", iv_count - n0, 0);
        check("glitch_ferr", rx_frame_err, 0);
        send_word(32'hA1B2C3D4);
        wait_iv(n0);
        check("glitch_word", in_data, 32'hA1B2C3D4);
        check("glitch_pulses", iv_count - n0, 1);

        // 3: word held pending until in_req rises
        in_req = 1'b0;
        repeat (4) tick();
        n0 = iv_count;
        send_word(32'h00000005);
        repeat (100) tick();
        check("hold_nopulse", iv_count - n0, 0);
        x = cyc;
        in_req = 1'b1;
        wait_iv(n0);
        check("hold_latency", iv_last_cyc, x + 1);
        check("hold_data", in_data, 32'h00000005);

        // 4: framing error mid-word, then a clean word
        tick();
        n0 = iv_count;
        send_byte(8'h77, 1'b1);
        send_byte(8'hAA, 1'b0);
        uart_rx = 1'b1;
        repeat (8) tick();
        check("ferr_set", rx_frame_err, 1);
        check("ferr_noword", iv_count - n0, 0);
        send_word(32'h01020304);
        wait_iv(n0);
        repeat (4) tick();
        check("ferr_word", in_data, 32'h01020304);
        check("ferr_pulses", iv_count - n0, 1);

        // overrun: second word replaces an undelivered first
        in_req = 1'b0;
        tick();
        n0 = iv_count;
        send_word(32'h11111111);
        check("ovr_clear", rx_overrun, 0);
        send_word(32'h22222222);
        repeat (4) tick();
        check("ovr_set", rx_overrun, 1);
        check("ovr_nopulse", iv_count - n0, 0);
        in_req = 1'b1;
        wait_iv(n0);
        repeat (4) tick();
        check("ovr_word", in_data, 32'h22222222);
        check("ovr_pulses", iv_count - n0, 1);
        in_req = 1'b0;

        // 5b: held out_req sends one word
        out_data = 32'h0F0F0F0F;
        tick();
        a0 = ack_count;
        out_req = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 340; i++) begin
            if (busy) bcnt++;
            tick();
        end
        check("held_acks", ack_count - a0, 1);
        check("held_busy", bcnt, 160);
        out_req = 1'b0;
        tick();

        // 6: reset during TX byte 2 and RX byte 1
        out_data = 32'h55AA55AA;
        tick();
        out_req = 1'b1;
        tick();
        out_req = 1'b0;
        repeat (39) tick();
        send_byte(8'h11, 1'b1);
        part = 8'h22;
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            uart_rx = part[i];
            repeat (CPB) tick();
        end
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        uart_rx = 1'b1;
        tick();
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_data", in_data, 0);
        check("mid_rst_ovr", rx_overrun, 0);
        check("mid_rst_ferr", rx_frame_err, 0);
        reset = 1'b0;
        repeat (10) tick();
        in_req = 1'b1;
        n0 = iv_count;
        send_word(32'hCAFEF00D);
        wait_iv(n0);
        repeat (4) tick();
        check("post_rst_word", in_data, 32'hCAFEF00D);
        check("post_rst_pulses", iv_count - n0, 1);
        check("post_rst_tx", uart_tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
